shift_sequencer: RTL

//  Multi-cycle controller for the RISC shift unit. Accepts one shift command
//  (operand, 5-bit amount, op1/op2 code) over a valid/ready handshake.

---
 rtl/shift_sequencer.sv | 110 +++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Iterative shift unit: one handshaked command, one step per clock, result held until taken.
// Optional SHIFT_SEQ_FASTSTEP_EN: 4-bit steps while the remaining count is >= 4.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [AMT_W-1:0] shamt,
  input  logic             op1,
  input  logic             op2,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] res,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [AMT_W-1:0] ONE  = AMT_W'(1);
  localparam logic [AMT_W-1:0] ZERO = '0;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_res;
  logic [AMT_W-1:0] r_count;
  logic [1:0]       r_op;
  logic [AMT_W-1:0] w_step;
  logic [AMT_W-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_shifted;
  logic             w_accept;

`ifdef SHIFT_SEQ_FASTSTEP_EN
  localparam logic [AMT_W-1:0] FOUR = AMT_W'(4);
  // Coarse steps first; the last few bits go one at a time, so count never underflows.
  assign w_step = (r_count >= FOUR) ? FOUR : ONE;
`else
  assign w_step = ONE;
`endif

  assign w_count_nxt = r_count - w_step;
  assign w_accept    = start_valid && (r_state == IDLE);

  always_comb begin
    w_shifted = r_res << w_step;
    unique case (r_op)
      2'b01:   w_shifted = r_res >> w_step;
      2'b10:   w_shifted = $signed(r_res) >>> w_step;
      default: w_shifted = r_res << w_step;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (start_valid) begin
          w_state_nxt = (shamt == ZERO) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (w_count_nxt == ZERO) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (done_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res   <= '0;
      r_count <= '0;
      r_op    <= '0;
    end else if (w_accept) begin
      r_res   <= a;
      r_count <= shamt;
      r_op    <= {op2, op1};
    end else if (r_state == SHIFT) begin
      r_res   <= w_shifted;
      r_count <= w_count_nxt;
    end
  end

  assign start_ready = (r_state == IDLE);
  assign done_valid  = (r_state == DONE);
  assign busy        = (r_state != IDLE);
  assign res         = r_res;

endmodule
